// File: rtl/ahb_mem_ws.sv
// AHB-Lite subordinate RAM with configurable width, depth and wait states.
// Out-of-range, unaligned and oversized transfers get a two-cycle ERROR response.
module ahb_mem_ws #(
   parameter int                      AddressWidth = 32,
   parameter int                      DataWidth    = 32,
   parameter int                      DepthWords   = 1024,
   parameter int                      WaitStates   = 0,
   parameter logic [AddressWidth-1:0] BaseAddress  = '0
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic                    HSEL,
   input  logic [AddressWidth-1:0] HADDR,
   input  logic [1:0]              HTRANS,
   input  logic                    HWRITE,
   input  logic [2:0]              HSIZE,
   input  logic [2:0]              HBURST,
   input  logic [DataWidth-1:0]    HWDATA,
   input  logic                    HREADY,
   output logic [DataWidth-1:0]    HRDATA,
   output logic                    HREADYOUT,
   output logic                    HRESP
);

   localparam int         NB = DataWidth / 8;
   localparam int         LB = $clog2(NB);
   localparam int         IW = (DepthWords > 1) ? $clog2(DepthWords) : 1;
   localparam logic [2:0] WS = 3'(WaitStates);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t               state_q, state_d;
   logic [2:0]           wcnt_q, wcnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [NB-1:0]        be_q, be_d;
   logic                 write_q, write_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;

   logic [DataWidth-1:0]    mem [DepthWords];
   logic [AddressWidth-1:0] offset, word, align_mask;
   logic [NB-1:0]           acc_be;
   logic [DataWidth-1:0]    rd_word;
   logic                    acc_err, accept, commit, rd_load;
   int                      lane, nbytes;

   logic unused_inputs;
   assign unused_inputs = ^{HBURST, HTRANS[0]};

   // Address-phase decode: error classification and byte-lane mask
   always_comb begin
      offset     = HADDR - BaseAddress;
      word       = offset >> LB;
      align_mask = (AddressWidth'(1) << HSIZE) - AddressWidth'(1);
      acc_err    = (HSIZE > 3'(LB)) || ((HADDR & align_mask) != '0) ||
                   (HADDR < BaseAddress) || (word >= AddressWidth'(DepthWords));
      lane       = int'(HADDR[LB-1:0]);
      nbytes     = 1 << HSIZE;
      for (int b = 0; b < NB; b++) begin
         acc_be[b] = (b >= lane) && (b < lane + nbytes);
      end
      accept = HSEL && HTRANS[1] && HREADY &&
               (state_q inside {S_IDLE, S_DATA, S_ERR2});
      commit = (state_q == S_DATA) && write_q;
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      idx_d   = idx_q;
      be_d    = be_q;
      write_d = write_q;
      rdata_d = rdata_q;
      rd_word = '0;
      case (state_q)
         S_WAIT: begin
            if (wcnt_q <= 3'd1) state_d = S_DATA;
            if (wcnt_q != 3'd0) wcnt_d = wcnt_q - 3'd1;
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            state_d = S_IDLE;
            if (accept) begin
               write_d = HWRITE;
               idx_d   = word[IW-1:0];
               be_d    = acc_be;
               if (acc_err) begin
                  state_d = S_ERR1;
               end else if (WS != 3'd0) begin
                  state_d = S_WAIT;
                  wcnt_d  = WS;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
      endcase
      // A read entering DATA sees bytes committed on this same edge
      rd_load = (state_d == S_DATA) && !write_d && ((state_q == S_WAIT) || accept);
      if (rd_load) begin
         if (int'(idx_d) < DepthWords) rd_word = mem[idx_d];
         for (int b = 0; b < NB; b++) begin
            if (commit && (idx_q == idx_d) && be_q[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
         end
         rdata_d = rd_word;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         wcnt_q  <= 3'd0;
         write_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge HCLK) begin
      idx_q <= idx_d;
      be_q  <= be_d;
   end

   // Storage is never reset; a reset abandons the pending commit
   always_ff @(posedge HCLK) begin
      if (!HRESET && commit) begin
         for (int b = 0; b < NB; b++) begin
            if (be_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   always_comb begin
      HREADYOUT = !(state_q inside {S_WAIT, S_ERR1});
      HRESP     = state_q inside {S_ERR1, S_ERR2};
      HRDATA    = rdata_q;
   end

endmodule

// File: tb/tb_ahb_mem_ws.sv
// Directed bench for ahb_mem_ws: 32-bit zero-wait, 64-bit and 32-bit three-wait instances.
module tb_ahb_mem_ws;

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        hrst, hsel, hwrite;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;
   logic [63:0] hwdata;
   int          sel = 0;
   int          checks = 0, errors = 0;

   logic        ro0, ro1, ro2, rs0, rs1, rs2;
   logic [31:0] rd0, rd2;
   logic [63:0] rd1;
   logic        hready_m, hresp_m;
   logic [63:0] hrdata_m;

   ahb_mem_ws #(.AddressWidth(32), .DataWidth(32), .DepthWords(16), .WaitStates(0),
                .BaseAddress(32'h0)) u_ws0 (
      .HCLK(clk), .HRESET(hrst), .HSEL(hsel && sel == 0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata[31:0]), .HREADY(ro0),
      .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

   ahb_mem_ws #(.AddressWidth(32), .DataWidth(64), .DepthWords(8), .WaitStates(0),
                .BaseAddress(32'h0)) u_b64 (
      .HCLK(clk), .HRESET(hrst), .HSEL(hsel && sel == 1), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(ro1),
      .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1));

   ahb_mem_ws #(.AddressWidth(32), .DataWidth(32), .DepthWords(8), .WaitStates(3),
                .BaseAddress(32'h100)) u_ws3 (
      .HCLK(clk), .HRESET(hrst), .HSEL(hsel && sel == 2), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata[31:0]), .HREADY(ro2),
      .HRDATA(rd2), .HREADYOUT(ro2), .HRESP(rs2));

   always_comb begin
      case (sel)
         0:       begin hready_m = ro0; hresp_m = rs0; hrdata_m = {32'h0, rd0}; end
         1:       begin hready_m = ro1; hresp_m = rs1; hrdata_m = rd1; end
         default: begin hready_m = ro2; hresp_m = rs2; hrdata_m = {32'h0, rd2}; end
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_ph(input logic w, input logic [31:0] a, input logic [2:0] sz,
                          input logic [1:0] tr);
      hsel = 1'b1; hwrite = w; haddr = a; hsize = sz; htrans = tr;
   endtask

   task automatic bus_idle();
      hsel = 1'b0; hwrite = 1'b0; htrans = T_IDLE;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d,
                           output logic resp, output int waits);
      addr_ph(1'b1, a, sz, T_NSEQ);
      tick();
      bus_idle();
      hwdata = d;
      waits = 0;
      while (!hready_m && waits < 20) begin tick(); waits++; end
      resp = hresp_m;
      tick();
   endtask

   task automatic do_read(input logic [31:0] a, input logic [2:0] sz, output logic [63:0] d,
                          output logic resp, output int waits);
      addr_ph(1'b0, a, sz, T_NSEQ);
      tick();
      bus_idle();
      waits = 0;
      while (!hready_m && waits < 20) begin tick(); waits++; end
      d = hrdata_m;
      resp = hresp_m;
      tick();
   endtask

   task automatic test_reset();
      hrst = 1'b1; hburst = 3'b000; hwdata = '0; haddr = '0; hsize = 3'd2;
      bus_idle();
      tick(); tick();
      hrst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checks++;
         if (hready_m !== 1'b1) begin errors++; $display("FAIL reset_hreadyout[%0d]: got %b expected 1", s, hready_m); end
         checks++;
         if (hresp_m !== 1'b0) begin errors++; $display("FAIL reset_hresp[%0d]: got %b expected 0", s, hresp_m); end
         checks++;
         if (hrdata_m !== 64'h0) begin errors++; $display("FAIL reset_hrdata[%0d]: got %h expected 0", s, hrdata_m); end
      end
   endtask

   task automatic test_zero_wait();
      logic [63:0] d; logic r; int w;
      sel = 0;
      addr_ph(1'b1, 32'h10, 3'd2, T_NSEQ);
      tick();
      checks++;
      if (hready_m !== 1'b1 || hresp_m !== 1'b0) begin
         errors++; $display("FAIL zw_write_phase: got ready=%b resp=%b expected ready=1 resp=0", hready_m, hresp_m);
      end
      hwdata = 64'hDEADBEEF;
      addr_ph(1'b0, 32'h10, 3'd2, T_NSEQ);
      tick();
      bus_idle();
      checks++;
      if (hrdata_m !== 64'hDEADBEEF) begin errors++; $display("FAIL zw_pipelined_read: got %h expected deadbeef", hrdata_m); end
      checks++;
      if (hready_m !== 1'b1 || hresp_m !== 1'b0) begin
         errors++; $display("FAIL zw_read_phase: got ready=%b resp=%b expected ready=1 resp=0", hready_m, hresp_m);
      end
      tick();
      do_read(32'h10, 3'd2, d, r, w);
      checks++;
      if (d !== 64'hDEADBEEF || w !== 0) begin errors++; $display("FAIL zw_reread: got %h waits %0d expected deadbeef waits 0", d, w); end
   endtask

   task automatic test_byte_lanes();
      logic [63:0] d; logic r; int w;
      sel = 1;
      do_write(32'h0, 3'd3, 64'h0, r, w);
      do_write(32'h5, 3'd0, 64'h0000_AA00_0000_0000, r, w);
      do_write(32'h2, 3'd1, 64'h0000_0000_1234_0000, r, w);
      do_read(32'h0, 3'd3, d, r, w);
      checks++;
      if (d !== 64'h0000AA0012340000) begin errors++; $display("FAIL lanes_word0: got %h expected 0000aa0012340000", d); end
      checks++;
      if (r !== 1'b0 || w !== 0) begin errors++; $display("FAIL lanes_resp: got resp=%b waits=%0d expected 0 0", r, w); end
      do_write(32'h8, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, r, w);
      do_write(32'h8, 3'd0, 64'h0000_0000_0000_0011, r, w);
      do_write(32'hC, 3'd2, 64'h89AB_CDEF_0000_0000, r, w);
      do_read(32'h8, 3'd3, d, r, w);
      checks++;
      if (d !== 64'h89ABCDEFFFFFFF11) begin errors++; $display("FAIL lanes_word1: got %h expected 89abcdefffffff11", d); end
   endtask

   task automatic test_wait_states();
      logic [63:0] d, da, db; logic r; int w, edges;
      sel = 2;
      do_write(32'h104, 3'd2, 64'hCAFEF00D, r, w);
      checks++;
      if (w !== 3) begin errors++; $display("FAIL ws_write_waits: got %0d expected 3", w); end
      do_write(32'h108, 3'd2, 64'h12345678, r, w);
      addr_ph(1'b0, 32'h104, 3'd2, T_NSEQ);
      tick();
      bus_idle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (hready_m !== 1'b0) begin errors++; $display("FAIL ws_stall[%0d]: got hreadyout %b expected 0", i, hready_m); end
         tick();
      end
      checks++;
      if (hready_m !== 1'b1 || hrdata_m !== 64'hCAFEF00D) begin
         errors++; $display("FAIL ws_data: got ready=%b data=%h expected ready=1 data=cafef00d", hready_m, hrdata_m);
      end
      tick();
      // back-to-back: second address is held on the bus through the stall
      addr_ph(1'b0, 32'h104, 3'd2, T_NSEQ);
      tick();
      addr_ph(1'b0, 32'h108, 3'd2, T_NSEQ);
      edges = 0;
      while (!hready_m && edges < 20) begin tick(); edges++; end
      da = hrdata_m;
      tick(); edges++;
      bus_idle();
      while (!hready_m && edges < 40) begin tick(); edges++; end
      db = hrdata_m;
      tick(); edges++;
      checks++;
      if (edges !== 8) begin errors++; $display("FAIL ws_b2b_cycles: got %0d expected 8", edges); end
      checks++;
      if (da !== 64'hCAFEF00D || db !== 64'h12345678) begin
         errors++; $display("FAIL ws_b2b_data: got %h %h expected cafef00d 12345678", da, db);
      end
      d = '0;
      do_read(32'h120, 3'd2, d, r, w);
      checks++;
      if (r !== 1'b1 || w !== 1) begin errors++; $display("FAIL ws_range_err: got resp=%b waits=%0d expected 1 1", r, w); end
      do_read(32'hFC, 3'd2, d, r, w);
      checks++;
      if (r !== 1'b1 || w !== 1) begin errors++; $display("FAIL ws_below_base: got resp=%b waits=%0d expected 1 1", r, w); end
   endtask

   task automatic test_errors();
      logic [63:0] d; logic r; int w;
      sel = 0;
      addr_ph(1'b0, 32'h40, 3'd2, T_NSEQ);
      tick();
      bus_idle();
      checks++;
      if (hready_m !== 1'b0 || hresp_m !== 1'b1) begin
         errors++; $display("FAIL err1_phase: got ready=%b resp=%b expected ready=0 resp=1", hready_m, hresp_m);
      end
      tick();
      checks++;
      if (hready_m !== 1'b1 || hresp_m !== 1'b1) begin
         errors++; $display("FAIL err2_phase: got ready=%b resp=%b expected ready=1 resp=1", hready_m, hresp_m);
      end
      addr_ph(1'b0, 32'h10, 3'd2, T_NSEQ);
      tick();
      bus_idle();
      checks++;
      if (hready_m !== 1'b1 || hresp_m !== 1'b0 || hrdata_m !== 64'hDEADBEEF) begin
         errors++; $display("FAIL err_then_read: got ready=%b resp=%b data=%h expected 1 0 deadbeef", hready_m, hresp_m, hrdata_m);
      end
      tick();
      do_read(32'h1, 3'd1, d, r, w);
      checks++;
      if (r !== 1'b1 || w !== 1) begin errors++; $display("FAIL err_unaligned: got resp=%b waits=%0d expected 1 1", r, w); end
      do_write(32'h10, 3'd3, 64'h1111_1111_1111_1111, r, w);
      checks++;
      if (r !== 1'b1 || w !== 1) begin errors++; $display("FAIL err_oversize: got resp=%b waits=%0d expected 1 1", r, w); end
      do_read(32'h10, 3'd2, d, r, w);
      checks++;
      if (d !== 64'hDEADBEEF || r !== 1'b0) begin errors++; $display("FAIL err_no_write: got %h resp %b expected deadbeef 0", d, r); end
   endtask

   task automatic test_burst_busy();
      logic [1:0]  tr_t [6];
      logic [31:0] ad_t [6];
      logic [31:0] dt_t [6];
      logic [63:0] d, exp_d; logic r; int w;
      sel = 0;
      tr_t = '{T_NSEQ, T_BUSY, T_SEQ, T_IDLE, T_SEQ, T_SEQ};
      ad_t = '{32'h20, 32'h30, 32'h24, 32'h34, 32'h28, 32'h2C};
      dt_t = '{32'hA0A0A0A0, 32'hBADBAD00, 32'hA1A1A1A1, 32'hBADBAD01, 32'hA2A2A2A2, 32'hA3A3A3A3};
      do_write(32'h30, 3'd2, 64'h30303030, r, w);
      do_write(32'h34, 3'd2, 64'h34343434, r, w);
      hburst = 3'b011;
      for (int i = 0; i <= 6; i++) begin
         hwdata = (i > 0) ? {32'h0, dt_t[i-1]} : 64'h0;
         if (i < 6) addr_ph(1'b1, ad_t[i], 3'd2, tr_t[i]);
         else bus_idle();
         tick();
         checks++;
         if (hready_m !== 1'b1 || hresp_m !== 1'b0) begin
            errors++; $display("FAIL burst_wr[%0d]: got ready=%b resp=%b expected 1 0", i, hready_m, hresp_m);
         end
      end
      exp_d = hrdata_m;
      for (int i = 0; i < 6; i++) begin
         addr_ph(1'b0, ad_t[i], 3'd2, tr_t[i]);
         tick();
         if (tr_t[i][1]) exp_d = {32'h0, dt_t[i]};
         checks++;
         if (hrdata_m !== exp_d || hready_m !== 1'b1 || hresp_m !== 1'b0) begin
            errors++; $display("FAIL burst_rd[%0d]: got data=%h ready=%b resp=%b expected %h 1 0", i, hrdata_m, hready_m, hresp_m, exp_d);
         end
      end
      bus_idle();
      hburst = 3'b000;
      tick();
      do_read(32'h30, 3'd2, d, r, w);
      checks++;
      if (d !== 64'h30303030) begin errors++; $display("FAIL busy_no_write: got %h expected 30303030", d); end
      do_read(32'h34, 3'd2, d, r, w);
      checks++;
      if (d !== 64'h34343434) begin errors++; $display("FAIL idle_no_write: got %h expected 34343434", d); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] d; logic r; int w;
      sel = 2;
      do_write(32'h10C, 3'd2, 64'h55555555, r, w);
      addr_ph(1'b1, 32'h10C, 3'd2, T_NSEQ);
      tick();
      bus_idle();
      hwdata = 64'hAAAAAAAA;
      tick();
      checks++;
      if (hready_m !== 1'b0) begin errors++; $display("FAIL rst_pre_wait: got hreadyout %b expected 0", hready_m); end
      hrst = 1'b1;
      tick();
      hrst = 1'b0;
      checks++;
      if (hready_m !== 1'b1 || hresp_m !== 1'b0 || hrdata_m !== 64'h0) begin
         errors++; $display("FAIL rst_mid_outputs: got ready=%b resp=%b data=%h expected 1 0 0", hready_m, hresp_m, hrdata_m);
      end
      do_read(32'h10C, 3'd2, d, r, w);
      checks++;
      if (d !== 64'h55555555 || w !== 3) begin errors++; $display("FAIL rst_mid_mem: got %h waits %0d expected 55555555 waits 3", d, w); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_zero_wait();
      test_byte_lanes();
      test_wait_states();
      test_errors();
      test_burst_busy();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_mem_ws.md
# ahb_mem_ws

Parametrised AHB-Lite subordinate RAM with configurable data width, depth and wait states. Generates two-cycle ERROR responses for out-of-range, unaligned and oversized transfers. Sits behind `renode_ahb_manager` (or an interconnect slot) in co-simulation tops and replaces the fixed 32-bit zero-wait memory for bus-protocol and stall testing. Byte-lane writes are little-endian; storage is not reset.

## Interface

Parameters:
- `AddressWidth`, 32: width of `HADDR`.
- `DataWidth`, 32: bus width in bits. Legal values are 32 and 64.
- `DepthWords`, 1024: number of `DataWidth`-bit words. Need not be a power of two.
- `WaitStates`, 0: stall cycles (0..7) inserted in every OKAY data phase.
- `BaseAddress`, 0: byte address of word 0. Must be `DataWidth/8`-aligned.

Ports:
- `HCLK` input 1: clock; all logic on the rising edge.
- `HRESET` input 1: reset, synchronous, active-high.
- `HSEL` input 1: subordinate select.
- `HADDR` input `AddressWidth`: byte address.
- `HTRANS` input 2: IDLE/BUSY/NONSEQ/SEQ.
- `HWRITE` input 1: 1 means write.
- `HSIZE` input 3: log2 of transfer bytes.
- `HBURST` input 3: accepted and ignored; every beat is handled independently.
- `HWDATA` input `DataWidth`: write data, sampled in the data phase.
- `HREADY` input 1: bus-level ready; qualifies address-phase sampling.
- `HRDATA` output `DataWidth`: read data.
- `HREADYOUT` output 1: data-phase completion.
- `HRESP` output 1: 0 means OKAY, 1 means ERROR.

## Operation

- **Address-phase accept** occurs at a rising edge when `HSEL && HTRANS[1] && HREADY`. At accept, register address, write flag, size and error classification.
  - IDLE or BUSY with `HSEL`: zero-wait OKAY, no access.
- **Error classification**, any one of these gives ERROR:
  - `HSIZE > log2(DataWidth/8)`.
  - `HADDR` not aligned to `2^HSIZE`.
  - `HADDR < BaseAddress`.
  - word index `(HADDR-BaseAddress)>>log2(DataWidth/8)` is `>= DepthWords`.
- **FSM states:**
  - IDLE to WAIT, on an OKAY accept with `WaitStates>0`.
  - IDLE to DATA, on an OKAY accept with `WaitStates==0`.
  - IDLE to ERR1, on an error accept.
  - WAIT: counts `WaitStates` cycles, then goes to DATA.
  - DATA: `HREADYOUT=1`. Goes to IDLE, or directly to the next state on a pipelined accept in the same cycle.
  - ERR1: `HREADYOUT=0`, `HRESP=1`. Goes to ERR2.
  - ERR2: `HREADYOUT=1`, `HRESP=1`. Goes to IDLE, or to the next state on a pipelined accept.
- **Wait states:** ERROR responses never insert wait states.
- **Writes:**
  - Commit at the edge ending DATA.
  - Byte lanes are `[a, a+2^HSIZE)`, where lane index = `HADDR[log2(DataWidth/8)-1:0]`.
  - Other lanes are untouched.
  - ERROR transfers never write.
- **Reads:**
  - `HRDATA` carries the full stored word, all lanes, during DATA.
  - In all other states `HRDATA` holds its last value.
- **Read after write:** a read accepted on the same edge that commits a write to the same word returns the newly written bytes.
- **Pipelining:** during WAIT and ERR1, `HREADY` is low, so no accept occurs and address-phase inputs are ignored.

## Timing

- **Reset values:** `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`, FSM in IDLE, wait counter 0.
- **Reset mid-transfer:** the in-flight transfer is abandoned and no write occurs. Memory contents are preserved.
- **Latency:** OKAY transfers complete `WaitStates+1` cycles after accept, so back-to-back throughput is one beat per `WaitStates+1` cycles. ERROR completes 2 cycles after accept.
- **Outputs:** all outputs are registered or state-decoded; there is no combinational path from any input to `HREADYOUT` or `HRESP`.
- **Wait counter:** 3 bits, loaded at accept, decremented in WAIT. It does not wrap.

## Test plan

- **Zero-wait write/read:** `DataWidth=32`, `WaitStates=0`. Write word `0xDEADBEEF` at `0x10`, then read `0x10` pipelined → `HRDATA=0xDEADBEEF`, `HREADYOUT` stays 1, `HRESP=0`.
- **Byte lanes:** `DataWidth=64`. Write doubleword `0x0` at `0x0`, then byte `0xAA` at `0x5`, then halfword `0x1234` at `0x2` → read `0x0` returns `0x0000AA0012340000`.
- **Wait states:** `WaitStates=3`. Read → `HREADYOUT` low exactly 3 cycles after accept, then high one cycle with data. Two back-to-back reads take 8 cycles total.
- **Errors:**
  - Read at `BaseAddress+DepthWords*4` → ERR1 then ERR2 (`HREADYOUT` 0 then 1, `HRESP` 1 both cycles).
  - Unaligned halfword at `0x1` → same ERR1/ERR2 response.
  - `HSIZE=3` on the 32-bit bus → same response, with no memory change.
- **IDLE/BUSY, HBURST, reset:**
  - IDLE/BUSY cycles interleaved in an INCR4 burst → OKAY, no access, burst data correct.
  - Assert `HRESET` in WAIT of a write → outputs at reset values next cycle and the targeted word is unchanged.
